// File: rtl/ifft8_seq.sv
// ifft8_seq: time-multiplexed 8-point radix-2 inverse FFT.
// Loads 8 frequency bins one per beat, stores them in bit-reversed order, and runs 12
// butterflies (3 stages x 4) on one shared complex butterfly. Each stage halves its
// result, so the output carries the full 1/8 IDFT normalisation. Samples then stream
// out one per beat in natural order.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     bin handshake; in_re/in_im are signed 16-bit
//   out_valid/out_ready   sample handshake; out_re/out_im are signed 16-bit
//   out_last              high on output index 7
module ifft8_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_re,
  input  logic signed [15:0] in_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_re,
  output logic signed [15:0] out_im,
  output logic               out_last
);

  typedef enum logic [1:0] {StLoad, StComp, StOut} state_e;

  state_e     state_q, state_d;
  logic [2:0] load_cnt_q, load_cnt_d;
  logic [3:0] bf_cnt_q, bf_cnt_d;
  logic [2:0] out_cnt_q, out_cnt_d;
  logic       load_en, bf_en;

  logic signed [15:0] buf_re_q [8];
  logic signed [15:0] buf_im_q [8];

  // Butterfly addressing and arithmetic
  logic [1:0]         stage, bsel, tw_idx;
  logic [2:0]         top_idx, bot_idx, load_idx;
  logic signed [15:0] w_re, w_im, a_re, a_im, b_re, b_im;
  logic signed [32:0] acc_re, acc_im;
  logic signed [17:0] t_re, t_im, a18_re, a18_im;
  logic signed [17:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [15:0] top_re, top_im, bot_re, bot_im;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7fff;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  assign load_idx = {load_cnt_q[0], load_cnt_q[1], load_cnt_q[2]};

  always_comb begin
    stage = bf_cnt_q[3:2];
    bsel  = bf_cnt_q[1:0];
    case (stage)
      2'd0: begin
        top_idx = {bsel, 1'b0};
        tw_idx  = 2'd0;
      end
      2'd1: begin
        top_idx = {bsel[1], 1'b0, bsel[0]};
        tw_idx  = {bsel[0], 1'b0};
      end
      default: begin
        top_idx = {1'b0, bsel};
        tw_idx  = bsel;
      end
    endcase
    bot_idx = top_idx + (3'd1 << stage);

    // Inverse twiddles cos + j*sin in Q1.15
    case (tw_idx)
      2'd0:    begin w_re = 16'sd32767;  w_im = 16'sd0;     end
      2'd1:    begin w_re = 16'sd23170;  w_im = 16'sd23170; end
      2'd2:    begin w_re = 16'sd0;      w_im = 16'sd32767; end
      default: begin w_re = -16'sd23170; w_im = 16'sd23170; end
    endcase

    a_re = buf_re_q[top_idx];
    a_im = buf_im_q[top_idx];
    b_re = buf_re_q[bot_idx];
    b_im = buf_im_q[bot_idx];

    // Full-width product sums, rounded, then >>> 15 yields an 18-bit t
    acc_re = 33'(b_re) * 33'(w_re) - 33'(b_im) * 33'(w_im) + 33'sd16384;
    acc_im = 33'(b_re) * 33'(w_im) + 33'(b_im) * 33'(w_re) + 33'sd16384;
    t_re   = acc_re[32:15];
    t_im   = acc_im[32:15];

    a18_re = 18'(a_re);
    a18_im = 18'(a_im);
    sum_re = (a18_re + t_re) >>> 1;
    sum_im = (a18_im + t_im) >>> 1;
    dif_re = (a18_re - t_re) >>> 1;
    dif_im = (a18_im - t_im) >>> 1;
    top_re = sat16(sum_re);
    top_im = sat16(sum_im);
    bot_re = sat16(dif_re);
    bot_im = sat16(dif_im);
  end

  // Next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    bf_cnt_d   = bf_cnt_q;
    out_cnt_d  = out_cnt_q;
    load_en    = 1'b0;
    bf_en      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_en    = 1'b1;
          load_cnt_d = load_cnt_q + 3'd1;
          if (load_cnt_q == 3'd7) begin
            state_d  = StComp;
            bf_cnt_d = 4'd0;
          end
        end
      end
      StComp: begin
        bf_en    = 1'b1;
        bf_cnt_d = bf_cnt_q + 4'd1;
        if (bf_cnt_q == 4'd11) begin
          state_d   = StOut;
          out_cnt_d = 3'd0;
        end
      end
      StOut: begin
        out_valid = 1'b1;
        out_last  = (out_cnt_q == 3'd7);
        if (out_ready) begin
          out_cnt_d = out_cnt_q + 3'd1;
          if (out_cnt_q == 3'd7) begin
            state_d    = StLoad;
            load_cnt_d = 3'd0;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign out_re = buf_re_q[out_cnt_q];
  assign out_im = buf_im_q[out_cnt_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      load_cnt_q <= 3'd0;
      bf_cnt_q   <= 4'd0;
      out_cnt_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      bf_cnt_q   <= bf_cnt_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (load_en) begin
      buf_re_q[load_idx] <= in_re;
      buf_im_q[load_idx] <= in_im;
    end else if (bf_en) begin
      buf_re_q[top_idx] <= top_re;
      buf_im_q[top_idx] <= top_im;
      buf_re_q[bot_idx] <= bot_re;
      buf_im_q[bot_idx] <= bot_im;
    end
  end

endmodule

// File: tb/tb_ifft8_seq.sv
// Self-checking bench for ifft8_seq: directed test cases plus random frames, with a
// scoreboard queue filled by the stimulus process and drained by a monitor.
module tb_ifft8_seq;

  logic               clk, rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [15:0] in_re, in_im, out_re, out_im;

  ifft8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last)
  );

  typedef struct {
    int re;
    int im;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    lat_q[$];
  int    n_vec = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    mon_idx = 0;
  bit    lat_done = 0;
  bit    rnd_ready = 0;
  int    stall_left = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference: bit-reversed load, then 3 in-place radix-2 stages on plain integers.
  function automatic void model(input int xr[8], input int xi[8],
                                output int yr[8], output int yi[8]);
    int     wr[4];
    int     wi[4];
    int     h, top, bot, tk, r;
    longint tr, ti;
    int     nr0, ni0, nr1, ni1;
    wr = '{32767, 23170, 0, -23170};
    wi = '{0, 23170, 32767, 23170};
    for (int k = 0; k < 8; k++) begin
      r = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      yr[r] = xr[k];
      yi[r] = xi[k];
    end
    for (int s = 0; s < 3; s++) begin
      h = 1 << s;
      for (int b = 0; b < 4; b++) begin
        top = ((b >> s) << (s + 1)) | (b & (h - 1));
        bot = top + h;
        tk  = (b & (h - 1)) << (2 - s);
        tr  = (longint'(yr[bot]) * wr[tk] - longint'(yi[bot]) * wi[tk] + 16384) >>> 15;
        ti  = (longint'(yr[bot]) * wi[tk] + longint'(yi[bot]) * wr[tk] + 16384) >>> 15;
        nr0 = sat((longint'(yr[top]) + tr) >>> 1);
        ni0 = sat((longint'(yi[top]) + ti) >>> 1);
        nr1 = sat((longint'(yr[top]) - tr) >>> 1);
        ni1 = sat((longint'(yi[top]) - ti) >>> 1);
        yr[top] = nr0;
        yi[top] = ni0;
        yr[bot] = nr1;
        yi[bot] = ni1;
      end
    end
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Sends one frame; pushes expected beats once bin 7 is accepted. acc_cyc = cycle of that accept.
  task automatic send_frame(input int xr[8], input int xi[8], input bit gaps,
                            output int acc_cyc);
    int  yr[8];
    int  yi[8];
    int  wait_n;
    bit  took;
    beat_t bt;
    model(xr, xi, yr, yi);
    acc_cyc = -1;
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1;
      in_re    = 16'(xr[k]);
      in_im    = 16'(xi[k]);
      wait_n   = 0;
      do begin
        took = in_ready;
        @(posedge clk); #1;
        wait_n++;
      end while (!took && wait_n < 300);
      if (!took) begin
        n_vec++;
        n_fail++;
        $display("FAIL accept_timeout: bin %0d not accepted, want accept within 300 cycles", k);
        in_valid = 0;
        return;
      end
    end
    in_valid = 0;
    acc_cyc  = cyc;
    for (int n = 0; n < 8; n++) begin
      bt.re = yr[n];
      bt.im = yi[n];
      bt.last = (n == 7);
      exp_q.push_back(bt);
    end
    lat_q.push_back(cyc);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete();
    lat_q.delete();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
  endtask

  // Monitor: compares every presented beat against the queue head, pops on handshake.
  always @(negedge clk) begin
    beat_t bt;
    if (rst) begin
      mon_idx  = 0;
      lat_done = 0;
    end else if (out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got (%0d,%0d) with no beat outstanding", out_re, out_im);
      end else begin
        bt = exp_q[0];
        if (int'(out_re) != bt.re || int'(out_im) != bt.im || out_last != bt.last ||
            in_ready != 1'b0) begin
          n_fail++;
          $display("FAIL beat%0d: got (%0d,%0d,last=%0b,in_ready=%0b) want (%0d,%0d,last=%0b,in_ready=0)",
                   mon_idx, out_re, out_im, out_last, in_ready, bt.re, bt.im, bt.last);
        end
        if (mon_idx == 0 && !lat_done && lat_q.size() > 0) begin
          chk("latency", cyc, lat_q.pop_front() + 12);
          lat_done = 1;
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          mon_idx = (mon_idx + 1) % 8;
          if (mon_idx == 0) lat_done = 0;
        end
      end
    end
  end

  // out_ready driver
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && out_valid && mon_idx == 3) begin
        out_ready = 0;
        stall_left--;
      end else begin
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  initial begin
    int          xr[8];
    int          xi[8];
    int          a1, a2;
    logic [31:0] r;
    rst      = 1;
    in_valid = 0;
    in_re    = 0;
    in_im    = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Impulse
    xr = '{8192, 0, 0, 0, 0, 0, 0, 0};
    xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(xr, xi, 0, a1);
    // DC
    xr = '{8000, 0, 0, 0, 0, 0, 0, 0};
    send_frame(xr, xi, 0, a1);
    // Tone on bin 1
    xr = '{0, 8192, 0, 0, 0, 0, 0, 0};
    send_frame(xr, xi, 0, a1);
    // Full-scale negative on every bin
    xr = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    xi = xr;
    send_frame(xr, xi, 0, a1);
    drain();

    // Tone with input gaps and a 5-cycle stall at n=3
    xr = '{0, 8192, 0, 0, 0, 0, 0, 0};
    xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    stall_left = 5;
    send_frame(xr, xi, 1, a1);
    drain();
    chk("stall_consumed", stall_left, 0);

    // Reset at COMP c=5, then a fresh impulse frame
    send_frame(xr, xi, 0, a1);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    xr = '{8192, 0, 0, 0, 0, 0, 0, 0};
    send_frame(xr, xi, 0, a1);
    // Two back-to-back frames: bin-7 accepts 28 cycles apart
    send_frame(xr, xi, 0, a1);
    send_frame(xr, xi, 0, a2);
    chk("frame_period", a2 - a1, 28);
    drain();

    // Random frames with random gaps and random backpressure
    rnd_ready = 1;
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 8; k++) begin
        r = $urandom;
        xr[k] = int'($signed(r[15:0]));
        xi[k] = int'($signed(r[31:16]));
      end
      send_frame(xr, xi, 1, a1);
    end
    drain();
    rnd_ready = 0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
